// File: rtl/mem_pkg.sv
// Shared definitions for the simple-dual-port memory family.
//   mem_state_e : clear-sequencer states (CLEAR, READY)
//   lane_count  : number of 8-bit byte lanes in a data word
//   depth       : number of words addressed by an address of a given width
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_sdp_core.sv
// Bare inferable simple-dual-port array with byte-lane write enables.
// Ports:
//   clock, reset : rising-edge clock; synchronous active-high reset (read register only)
//   wen, waddr, wdata, wmask : synchronous write, bit i of wmask covers bits [8i+7:8i]
//   ren, raddr   : read request; data appears on rdata one cycle later
//   rdata        : registered read data, holds when ren is low
module mem_sdp_core
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic                  ren,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int LANES = lane_count(DATA_W);
    localparam int DEPTH = depth(ADDR_W);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array is deliberately never reset; a reset would
    // turn it into thousands of flops instead of a RAM macro.
    always_ff @(posedge clock) begin
        if (wen) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem_array[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register sees the pre-write contents on a same-address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (ren) begin
            rdata_q <= mem_array[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_sdp_param.sv
// Parametrised simple-dual-port memory with byte-masked writes, read latency
// 1 or 2, optional same-address write-to-read bypass, read-valid strobe and a
// post-reset clear sequencer.
// Ports:
//   clock, reset       : single rising-edge clock; synchronous active-high reset
//   io_raddr, io_ren   : read request, accepted when io_R is high
//   io_rdata, io_rvalid: read result, valid READ_LAT cycles after acceptance
//   io_waddr, io_wdata, io_wmask, io_wen : byte-masked write request
//   io_R               : memory ready; requests are ignored while low
module mem_sdp_param
    import mem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int READ_LAT       = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     io_raddr,
    input  logic                  io_ren,
    output logic [DATA_W-1:0]     io_rdata,
    output logic                  io_rvalid,
    input  logic [ADDR_W-1:0]     io_waddr,
    input  logic [DATA_W-1:0]     io_wdata,
    input  logic [DATA_W/8-1:0]   io_wmask,
    input  logic                  io_wen,
    output logic                  io_R
);

    localparam int LANES = lane_count(DATA_W);
    localparam int DEPTH = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_sdp_param: DATA_W must be a multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $error("mem_sdp_param: READ_LAT must be 1 or 2");
    end

    // ---------------- clear sequencer ----------------
    mem_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    // NOTE: every sequential assignment uses <= so all flops sample the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY:   ready_q <= 1'b1;
                default: state_q <= READY;
            endcase
        end
    end

    assign io_R = ready_q;

    // ---------------- request gating ----------------
    logic                rd_acc;
    logic                wr_acc;
    logic                core_wen;
    logic [ADDR_W-1:0]   core_waddr;
    logic [DATA_W-1:0]   core_wdata;
    logic [LANES-1:0]    core_wmask;

    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_acc     = io_ren && ready_q;
        wr_acc     = io_wen && ready_q;
        core_wen   = wr_acc;
        core_waddr = io_waddr;
        core_wdata = io_wdata;
        core_wmask = io_wmask;
        // The clear sequencer owns the write port while it runs.
        if (state_q == CLEAR) begin
            core_wen   = 1'b1;
            core_waddr = cnt_q;
            core_wdata = '0;
            core_wmask = '1;
        end
    end

    logic [DATA_W-1:0] core_rdata;

    mem_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .wen   (core_wen),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .wmask (core_wmask),
        .ren   (rd_acc),
        .raddr (io_raddr),
        .rdata (core_rdata)
    );

    // ---------------- collision bypass ----------------
    // Captured alongside the read so the merge lines up with the core's
    // registered output; held between reads so io_rdata stays stable.
    logic [LANES-1:0]  byp_mask_d, byp_mask_q;
    logic [DATA_W-1:0] byp_data_d, byp_data_q;
    logic              valid1_d,   valid1_q;
    logic [DATA_W-1:0] merged;

    always_comb begin
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        valid1_d   = rd_acc;
        if (rd_acc) begin
            byp_data_d = io_wdata;
            byp_mask_d = (BYPASS != 0 && wr_acc && io_waddr == io_raddr) ? io_wmask : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
            valid1_q   <= 1'b0;
        end else begin
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
            valid1_q   <= valid1_d;
        end
    end

    always_comb begin
        merged = core_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (byp_mask_q[i]) begin
                merged[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    // ---------------- output stage ----------------
    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata2_d, rdata2_q;
        logic              valid2_d, valid2_q;

        always_comb begin
            valid2_d = valid1_q;
            rdata2_d = valid1_q ? merged : rdata2_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                rdata2_q <= '0;
                valid2_q <= 1'b0;
            end else begin
                rdata2_q <= rdata2_d;
                valid2_q <= valid2_d;
            end
        end

        assign io_rdata  = rdata2_q;
        assign io_rvalid = valid2_q;
    end else begin : g_lat1
        assign io_rdata  = merged;
        assign io_rvalid = valid1_q;
    end

endmodule

// File: tb/tb_mem_sdp_param.sv
// Self-checking bench for mem_sdp_param. Two instances share one stimulus
// stream: inst 0 = READ_LAT 2 / BYPASS 1, inst 1 = READ_LAT 1 / BYPASS 0.
// The reference model is a plain word array plus a per-instance schedule of
// expected read results indexed by the cycle they are due.
module tb_mem_sdp_param;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NL    = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] io_raddr, io_waddr;
    logic          io_ren, io_wen;
    logic [DW-1:0] io_wdata;
    logic [NL-1:0] io_wmask;

    logic [DW-1:0] rdata [2];
    logic          rvalid [2];
    logic          rdy [2];

    always #5 clock = ~clock;

    mem_sdp_param #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clock(clock), .reset(reset),
        .io_raddr(io_raddr), .io_ren(io_ren), .io_rdata(rdata[0]), .io_rvalid(rvalid[0]),
        .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wmask(io_wmask), .io_wen(io_wen),
        .io_R(rdy[0])
    );

    mem_sdp_param #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .io_raddr(io_raddr), .io_ren(io_ren), .io_rdata(rdata[1]), .io_rvalid(rvalid[1]),
        .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wmask(io_wmask), .io_wen(io_wen),
        .io_R(rdy[1])
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    bit            ready_m;
    int            clear_left;
    int            cyc;
    int            lat_of [2];
    int            byp_of [2];
    bit            ev [2][4];
    logic [DW-1:0] ed [2][4];
    logic [DW-1:0] last_m [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Apply one clock edge to the model, advance the DUTs, then compare.
    task automatic tick();
        logic [DW-1:0] val;
        int            slot;
        if (reset) begin
            ready_m    = 1'b0;
            clear_left = DEPTH;
            for (int k = 0; k < 2; k++) begin
                last_m[k] = '0;
                for (int s = 0; s < 4; s++) ev[k][s] = 1'b0;
            end
        end else if (!ready_m) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
            if (clear_left == 0) ready_m = 1'b1;
        end else begin
            if (io_ren) begin
                for (int k = 0; k < 2; k++) begin
                    val = mem_m[io_raddr];
                    if (byp_of[k] != 0 && io_wen && io_waddr == io_raddr) begin
                        for (int l = 0; l < NL; l++)
                            if (io_wmask[l]) val[8*l +: 8] = io_wdata[8*l +: 8];
                    end
                    slot         = (cyc + lat_of[k]) % 4;
                    ev[k][slot]  = 1'b1;
                    ed[k][slot]  = val;
                end
            end
            if (io_wen) begin
                for (int l = 0; l < NL; l++)
                    if (io_wmask[l]) mem_m[io_waddr][8*l +: 8] = io_wdata[8*l +: 8];
            end
        end

        @(posedge clock);
        cyc++;
        @(negedge clock);

        for (int k = 0; k < 2; k++) begin
            slot = cyc % 4;
            check($sformatf("io_R[%0d]", k), rdy[k], ready_m);
            if (ev[k][slot]) begin
                check($sformatf("rvalid[%0d]", k), rvalid[k], 1'b1);
                check($sformatf("rdata[%0d]", k), rdata[k], ed[k][slot]);
                last_m[k]   = ed[k][slot];
                ev[k][slot] = 1'b0;
            end else begin
                check($sformatf("rvalid_idle[%0d]", k), rvalid[k], 1'b0);
                check($sformatf("rdata_hold[%0d]", k), rdata[k], last_m[k]);
            end
        end
    endtask

    task automatic drive(input bit ren, input int raddr, input bit wen, input int waddr,
                         input logic [DW-1:0] wdata, input logic [NL-1:0] wmask);
        io_ren   = ren;
        io_raddr = AW'(raddr);
        io_wen   = wen;
        io_waddr = AW'(waddr);
        io_wdata = wdata;
        io_wmask = wmask;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0);
    endtask

    task automatic rand_cycle();
        int ra, wa;
        ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3);
        wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3);
        drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
              DW'($urandom), NL'($urandom_range(0, 3)));
    endtask

    // Release reset and wait for io_R with random traffic; length must equal DEPTH.
    task automatic clear_phase(input string tag);
        int n;
        reset = 1'b0;
        n = 0;
        while (n < 100) begin
            rand_cycle();
            n++;
            if (rdy[0]) break;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        lat_of = '{2, 1};
        byp_of = '{1, 0};
        cyc    = 0;
        reset  = 1'b1;
        io_ren = 1'b0; io_wen = 1'b0; io_raddr = '0; io_waddr = '0;
        io_wdata = '0; io_wmask = '0;

        idle(2);
        check("reset_rdata", rdata[0], 16'h0000);

        // Clear with ignored traffic, then every word reads zero.
        clear_phase("clear_len");
        for (int a = 0; a < DEPTH; a++) drive(1, a, 0, 0, '0, '0);
        idle(3);

        // Masked write merge.
        drive(0, 0, 1, 3, 16'hABCD, 2'b11);
        drive(0, 0, 1, 3, 16'h1200, 2'b10);
        drive(1, 3, 0, 0, '0, '0);
        check("mask_lat1_valid", rvalid[1], 1'b1);
        check("mask_lat1_data", rdata[1], 16'h12CD);
        check("mask_lat2_early", rvalid[0], 1'b0);
        idle(1);
        check("mask_lat2_valid", rvalid[0], 1'b1);
        check("mask_lat2_data", rdata[0], 16'h12CD);
        idle(2);

        // Collision: bypass instance merges the low lane, the other returns old data.
        drive(0, 0, 1, 5, 16'h1111, 2'b11);
        drive(1, 5, 1, 5, 16'h2222, 2'b01);
        check("coll_nobyp", rdata[1], 16'h1111);
        idle(1);
        check("coll_byp", rdata[0], 16'h1122);
        drive(1, 5, 0, 0, '0, '0);
        check("coll_after", rdata[1], 16'h1122);
        idle(3);

        // Streaming reads, 8 consecutive results.
        begin
            int nv;
            nv = 0;
            for (int a = 0; a < 8; a++) begin
                drive(1, a, 0, 0, '0, '0);
                if (rvalid[0]) nv++;
            end
            for (int i = 0; i < 4; i++) begin
                idle(1);
                if (rvalid[0]) nv++;
            end
            check("stream_count", nv, 8);
        end

        repeat (400) rand_cycle();

        // Reset with reads in flight, then the clear restarts.
        drive(1, 1, 0, 0, '0, '0);
        drive(1, 2, 0, 0, '0, '0);
        reset = 1'b1;
        rand_cycle();
        check("rst_drop_a", rvalid[0], 1'b0);
        check("rst_drop_b", rvalid[1], 1'b0);
        clear_phase("reclear_len");
        for (int a = 0; a < DEPTH; a++) drive(1, a, 0, 0, '0, '0);
        repeat (300) rand_cycle();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
